spi_master_sel_ctrl: RTL and testbench

SPI_MASTER_SEL_CTRL -- requirements
Module: spi_master_sel_ctrl

---
 rtl/spi_master_sel_ctrl_pkg.sv | 73 +++++++
 rtl/spi_master_sel_ctrl_chan_fsm.sv | 146 ++++++++++++++
 rtl/spi_master_sel_ctrl.sv | 116 +++++++++++
 tb/tb_spi_master_sel_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/spi_master_sel_ctrl_pkg.sv
// Shared definitions for the PFR SPI master-select controller.
//
// Contents:
//   sel_state_e    - per-channel ownership FSM states
//   chan_out_t     - per-state mux/reset/grant output bundle
//   Def*           - default timing parameter values (in clock cycles)
//   BMC, PCH       - channel index constants used by the arbiter
//   cnt_width()    - width of a counter able to hold the largest timing parameter
//   chan_outputs() - output decode for a given FSM state
package spi_master_sel_ctrl_pkg;

  // Default timing, all in iClk cycles.
  localparam int unsigned DefIdleCyc    = 8;
  localparam int unsigned DefRstHoldCyc = 16;
  localparam int unsigned DefGuardCyc   = 4;
  localparam int unsigned DefTimeoutCyc = 1024;

  // Channel indices into the arbiter vectors.
  localparam int unsigned BMC = 0;
  localparam int unsigned PCH = 1;

  typedef enum logic [2:0] {
    StHost     = 3'd0,
    StWaitIdle = 3'd1,
    StRstHold  = 3'd2,
    StSwitch   = 3'd3,
    StOwn      = 3'd4,
    StReturn   = 3'd5
  } sel_state_e;

  typedef struct packed {
    logic sel;    // 1: PFR drives the flash
    logic rst_n;  // flash reset, active low
    logic gnt;    // PFR owns the flash and the mux is settled
  } chan_out_t;

  // One counter width covers every timed state, so size it to the largest parameter.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                            input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return $clog2(m + 1);
  endfunction

  function automatic chan_out_t chan_outputs(input sel_state_e st);
    chan_out_t o;
    o.sel   = 1'b0;
    o.rst_n = 1'b1;
    o.gnt   = 1'b0;
    case (st)
      StRstHold: begin
        o.rst_n = 1'b0;
      end
      StSwitch: begin
        o.sel   = 1'b1;
        o.rst_n = 1'b0;
      end
      StOwn: begin
        o.sel = 1'b1;
        o.gnt = 1'b1;
      end
      StReturn: begin
        o.rst_n = 1'b0;
      end
      default: ;  // StHost, StWaitIdle: host owns the flash, reset released
    endcase
    return o;
  endfunction

endpackage

// File: rtl/spi_master_sel_ctrl_chan_fsm.sv
// One flash channel of the master-select controller: host chip-select synchronizer,
// ownership FSM and its timing counters.
//
// Ports:
//   clk_i      - clock
//   rst_i      - asynchronous active-high reset
//   bypass_i   - force the channel back to host ownership on the next edge
//   req_i      - PFR request for this flash (level)
//   start_i    - one-cycle pulse from the arbiter: this channel won arbitration
//   cs_n_i     - host chip select, asynchronous to clk_i
//   state_o    - current FSM state (used by the arbiter)
//   sel_o      - mux select, 1 = PFR drives the flash
//   rst_n_o    - flash reset, active low
//   gnt_o      - PFR owns the flash and the mux is settled
//   timeout_o  - one-cycle pulse: switch forced while the host CS was still busy
module spi_sel_chan_fsm
  import spi_master_sel_ctrl_pkg::*;
#(
  parameter int unsigned IdleCyc    = DefIdleCyc,
  parameter int unsigned RstHoldCyc = DefRstHoldCyc,
  parameter int unsigned GuardCyc   = DefGuardCyc,
  parameter int unsigned TimeoutCyc = DefTimeoutCyc
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       bypass_i,
  input  logic       req_i,
  input  logic       start_i,
  input  logic       cs_n_i,
  output sel_state_e state_o,
  output logic       sel_o,
  output logic       rst_n_o,
  output logic       gnt_o,
  output logic       timeout_o
);

  localparam int unsigned CntW = cnt_width(IdleCyc, RstHoldCyc, GuardCyc, TimeoutCyc);

  localparam logic [CntW-1:0] IdleLast    = CntW'(IdleCyc - 1);
  localparam logic [CntW-1:0] RstHoldLast = CntW'(RstHoldCyc - 1);
  localparam logic [CntW-1:0] GuardLast   = CntW'(GuardCyc - 1);
  localparam logic [CntW-1:0] TimeoutLast = CntW'(TimeoutCyc - 1);

  sel_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;     // cycles spent in the current state
  logic [CntW-1:0] idle_q, idle_d;   // consecutive synced CS_N-high cycles in StWaitIdle
  logic [1:0]      sync_q, sync_d;   // CS_N synchronizer, [1] is the usable copy
  logic            abort_q, abort_d; // request dropped at some point during StSwitch
  logic            timeout_q, timeout_d;

  logic            cs_idle;
  logic [CntW-1:0] cnt_inc, idle_inc;
  chan_out_t       outs;

  assign cs_idle = sync_q[1];

  // Saturating increments so a stalled count can never wrap into a false match.
  assign cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
  assign idle_inc = (idle_q == '1) ? idle_q : idle_q + 1'b1;

  always_comb begin
    sync_d = {sync_q[0], cs_n_i};
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_inc;
    idle_d    = idle_q;
    abort_d   = abort_q;
    timeout_d = 1'b0;

    unique case (state_q)
      StHost: begin
        if (start_i && req_i) state_d = StWaitIdle;
      end
      StWaitIdle: begin
        idle_d = cs_idle ? idle_inc : '0;
        if (!req_i) begin
          state_d = StHost;
        end else if (cs_idle && (idle_q == IdleLast)) begin
          state_d = StRstHold;
        end else if (cnt_q == TimeoutLast) begin
          // Host never went quiet long enough; take the flash anyway and flag it.
          state_d   = StRstHold;
          timeout_d = 1'b1;
        end
      end
      StRstHold: begin
        if (cnt_q == RstHoldLast) state_d = StSwitch;
      end
      StSwitch: begin
        if (!req_i) abort_d = 1'b1;
        // A drop anywhere in the guard window cancels the grant, even if req returns.
        if (cnt_q == GuardLast) state_d = (req_i && !abort_q) ? StOwn : StReturn;
      end
      StOwn: begin
        if (!req_i) state_d = StReturn;
      end
      StReturn: begin
        if (cnt_q == RstHoldLast) state_d = StHost;
      end
      default: begin
        state_d = StHost;
      end
    endcase

    if (bypass_i) begin
      state_d   = StHost;
      timeout_d = 1'b0;
    end

    // Every state entry starts its timing from zero.
    if (state_d != state_q) begin
      cnt_d   = '0;
      idle_d  = '0;
      abort_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= StHost;
      cnt_q     <= '0;
      idle_q    <= '0;
      sync_q    <= 2'b11;
      abort_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idle_q    <= idle_d;
      sync_q    <= sync_d;
      abort_q   <= abort_d;
      timeout_q <= timeout_d;
    end
  end

  // Outputs decode straight from the state flops so reset reaches them asynchronously.
  assign outs      = chan_outputs(state_q);
  assign state_o   = state_q;
  assign sel_o     = outs.sel;
  assign rst_n_o   = outs.rst_n;
  assign gnt_o     = outs.gnt;
  assign timeout_o = timeout_q;

endmodule

// File: rtl/spi_master_sel_ctrl.sv
// PFR SPI master-select controller for the BMC and PCH boot flashes.
// Two channel FSMs hand each flash between the host and the PFR engine; a round-robin
// arbiter here lets only one channel leave host ownership at a time.
//
// Ports:
//   iClk, iRst                    - clock, asynchronous active-high reset
//   iBypass                       - force host ownership of both flashes
//   iReqBmc, iReqPch              - PFR requests (level)
//   SPI_BMC_BOOT_CS_N             - BMC host chip select (asynchronous)
//   SPI_PCH_BMC_PFR_CS0_N         - PCH host chip select (asynchronous)
//   oGntBmc, oGntPch              - PFR owns the flash and the mux is settled
//   FM_SPI_PFR_BMC_BT_MASTER_SEL  - BMC flash mux, 1 = PFR
//   FM_SPI_PFR_PCH_MASTER_SEL     - PCH flash mux, 1 = PFR
//   RST_SPI_PFR_BMC_BOOT_N        - BMC flash reset, active low
//   RST_SPI_PFR_PCH_N             - PCH flash reset, active low
//   oTimeout                      - one-cycle pulse when a switch is forced on a busy CS
module spi_master_sel_ctrl
  import spi_master_sel_ctrl_pkg::*;
#(
  parameter int unsigned IDLE_CYC     = DefIdleCyc,
  parameter int unsigned RST_HOLD_CYC = DefRstHoldCyc,
  parameter int unsigned GUARD_CYC    = DefGuardCyc,
  parameter int unsigned TIMEOUT_CYC  = DefTimeoutCyc
) (
  input  logic iClk,
  input  logic iRst,
  input  logic iBypass,
  input  logic iReqBmc,
  input  logic iReqPch,
  input  logic SPI_BMC_BOOT_CS_N,
  input  logic SPI_PCH_BMC_PFR_CS0_N,
  output logic oGntBmc,
  output logic oGntPch,
  output logic FM_SPI_PFR_BMC_BT_MASTER_SEL,
  output logic FM_SPI_PFR_PCH_MASTER_SEL,
  output logic RST_SPI_PFR_BMC_BOOT_N,
  output logic RST_SPI_PFR_PCH_N,
  output logic oTimeout
);

  sel_state_e state_bmc, state_pch;
  logic       tmo_bmc, tmo_pch;
  logic [1:0] start_q, start_d;  // one-cycle win pulse per channel
  logic       ptr_q, ptr_d;      // round-robin: channel preferred on a tie
  logic       both_host;

  assign both_host = (state_bmc == StHost) && (state_pch == StHost);

  // A new winner is picked only with both channels home and no win still in flight,
  // which keeps at most one channel outside StHost.
  always_comb begin
    start_d = 2'b00;
    ptr_d   = ptr_q;
    if (!iBypass && both_host && (start_q == 2'b00)) begin
      if (iReqBmc && (!iReqPch || (ptr_q == 1'(BMC)))) begin
        start_d[BMC] = 1'b1;
        ptr_d        = 1'(PCH);
      end else if (iReqPch) begin
        start_d[PCH] = 1'b1;
        ptr_d        = 1'(BMC);
      end
    end
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      start_q <= 2'b00;
      ptr_q   <= 1'(BMC);
    end else begin
      start_q <= start_d;
      ptr_q   <= ptr_d;
    end
  end

  spi_sel_chan_fsm #(
    .IdleCyc   (IDLE_CYC),
    .RstHoldCyc(RST_HOLD_CYC),
    .GuardCyc  (GUARD_CYC),
    .TimeoutCyc(TIMEOUT_CYC)
  ) u_chan_bmc (
    .clk_i    (iClk),
    .rst_i    (iRst),
    .bypass_i (iBypass),
    .req_i    (iReqBmc),
    .start_i  (start_q[BMC]),
    .cs_n_i   (SPI_BMC_BOOT_CS_N),
    .state_o  (state_bmc),
    .sel_o    (FM_SPI_PFR_BMC_BT_MASTER_SEL),
    .rst_n_o  (RST_SPI_PFR_BMC_BOOT_N),
    .gnt_o    (oGntBmc),
    .timeout_o(tmo_bmc)
  );

  spi_sel_chan_fsm #(
    .IdleCyc   (IDLE_CYC),
    .RstHoldCyc(RST_HOLD_CYC),
    .GuardCyc  (GUARD_CYC),
    .TimeoutCyc(TIMEOUT_CYC)
  ) u_chan_pch (
    .clk_i    (iClk),
    .rst_i    (iRst),
    .bypass_i (iBypass),
    .req_i    (iReqPch),
    .start_i  (start_q[PCH]),
    .cs_n_i   (SPI_PCH_BMC_PFR_CS0_N),
    .state_o  (state_pch),
    .sel_o    (FM_SPI_PFR_PCH_MASTER_SEL),
    .rst_n_o  (RST_SPI_PFR_PCH_N),
    .gnt_o    (oGntPch),
    .timeout_o(tmo_pch)
  );

  // Only one channel can be in StWaitIdle at a time, so the OR never merges two pulses.
  assign oTimeout = tmo_bmc | tmo_pch;

endmodule

// File: tb/tb_spi_master_sel_ctrl.sv
// Directed + randomized bench for spi_master_sel_ctrl. Expected behaviour is computed
// from the timing rules: a request seen with both channels at home is granted after
// 1 + IDLE + RST_HOLD + GUARD edges, where the idle window restarts after the last
// CS_N-low sample (seen two edges late through the synchronizer).
module tb_spi_master_sel_ctrl;

  localparam int IDLE    = 8;
  localparam int RST     = 16;
  localparam int GUARD   = 4;
  localparam int TIMEOUT = 1024;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic bypass = 1'b0;
  logic req_bmc = 1'b0;
  logic req_pch = 1'b0;
  logic cs_bmc = 1'b1;
  logic cs_pch = 1'b1;
  logic gnt_bmc, gnt_pch, sel_bmc, sel_pch, rstn_bmc, rstn_pch, tmo;

  int checks = 0;
  int failures = 0;

  logic cs_pat [0:31];
  int   cs_len = 0;

  spi_master_sel_ctrl dut (
    .iClk                        (clk),
    .iRst                        (rst),
    .iBypass                     (bypass),
    .iReqBmc                     (req_bmc),
    .iReqPch                     (req_pch),
    .SPI_BMC_BOOT_CS_N           (cs_bmc),
    .SPI_PCH_BMC_PFR_CS0_N       (cs_pch),
    .oGntBmc                     (gnt_bmc),
    .oGntPch                     (gnt_pch),
    .FM_SPI_PFR_BMC_BT_MASTER_SEL(sel_bmc),
    .FM_SPI_PFR_PCH_MASTER_SEL   (sel_pch),
    .RST_SPI_PFR_BMC_BOOT_N      (rstn_bmc),
    .RST_SPI_PFR_PCH_N           (rstn_pch),
    .oTimeout                    (tmo)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input int idx, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s[%0d] observed=%b expected=%b", tag, idx, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic sel_of(input int ch);
    return (ch == 0) ? sel_bmc : sel_pch;
  endfunction
  function automatic logic rstn_of(input int ch);
    return (ch == 0) ? rstn_bmc : rstn_pch;
  endfunction
  function automatic logic gnt_of(input int ch);
    return (ch == 0) ? gnt_bmc : gnt_pch;
  endfunction

  task automatic set_req(input int ch, input logic v);
    if (ch == 0) req_bmc = v;
    else req_pch = v;
  endtask
  task automatic set_cs(input int ch, input logic v);
    if (ch == 0) cs_bmc = v;
    else cs_pch = v;
  endtask

  task automatic chk_home(input string tag, input int ch, input int idx);
    chk({tag, "_sel"}, idx, sel_of(ch), 1'b0);
    chk({tag, "_rstn"}, idx, rstn_of(ch), 1'b1);
    chk({tag, "_gnt"}, idx, gnt_of(ch), 1'b0);
  endtask

  // Raise the request of channel ch (both channels at home) and follow it to the grant.
  // cs_pat[k] is the CS_N level present at edge k after the request edge E0.
  task automatic acquire(input int ch, input string tag);
    int kmax;
    int ex;
    int ge;
    kmax = -1;
    for (int k = 0; k < cs_len; k++) if (!cs_pat[k]) kmax = k;
    ex = (kmax < 0) ? 1 + IDLE : 2 + kmax + IDLE;
    ge = ex + RST + GUARD;
    set_req(ch, 1'b1);
    set_cs(ch, (cs_len > 0) ? cs_pat[0] : 1'b1);
    step();  // E0: arbitration
    for (int i = 1; i <= ge + 1; i++) begin
      set_cs(ch, (i < cs_len) ? cs_pat[i] : 1'b1);
      step();
      chk({tag, "_rstn"}, i, rstn_of(ch), !(i >= ex && i < ge));
      chk({tag, "_sel"}, i, sel_of(ch), i >= ex + RST);
      chk({tag, "_gnt"}, i, gnt_of(ch), i >= ge);
      chk({tag, "_tmo"}, i, tmo, 1'b0);
      chk_home({tag, "_other"}, 1 - ch, i);
    end
  endtask

  // Drop the request of an owning channel: RETURN for RST cycles, then home.
  task automatic release_ch(input int ch, input string tag);
    set_req(ch, 1'b0);
    for (int i = 0; i <= RST; i++) begin
      step();
      chk({tag, "_gnt"}, i, gnt_of(ch), 1'b0);
      chk({tag, "_sel"}, i, sel_of(ch), 1'b0);
      chk({tag, "_rstn"}, i, rstn_of(ch), i >= RST);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk_home({tag, "_bmc"}, 0, 0);
    chk_home({tag, "_pch"}, 1, 0);
    chk({tag, "_tmo"}, 0, tmo, 1'b0);
  endtask

  initial begin
    // Reset state.
    step();
    step();
    chk_reset_vals("reset");
    rst = 1'b0;
    step();

    // Idle CS: BMC grant after 29 edges, reset low 20, select 4 before grant.
    cs_len = 0;
    acquire(0, "bmc_idle");
    release_ch(0, "bmc_idle_rel");

    // Random CS activity on a random channel during the idle wait.
    for (int t = 0; t < 4; t++) begin
      int ch;
      ch = int'($urandom_range(0, 1));
      cs_len = int'($urandom_range(1, 20));
      for (int k = 0; k < cs_len; k++) cs_pat[k] = 1'($urandom_range(0, 1));
      acquire(ch, $sformatf("rand%0d_ch%0d", t, ch));
      release_ch(ch, $sformatf("rand%0d_rel", t));
    end
    cs_len = 0;

    // PCH CS held busy: forced switch after TIMEOUT, grant RST+GUARD later.
    cs_pch = 1'b0;
    repeat (3) step();
    req_pch = 1'b1;
    step();  // E0
    for (int i = 1; i <= 1 + TIMEOUT + RST + GUARD + 1; i++) begin
      step();
      if (i >= 1 + TIMEOUT - 1 && i <= 1 + TIMEOUT + 1)
        chk("tmo_pulse", i, tmo, i == 1 + TIMEOUT);
      if (i >= 1 + TIMEOUT + RST + GUARD - 1)
        chk("tmo_gnt", i, gnt_pch, i >= 1 + TIMEOUT + RST + GUARD);
      if (i == 1 + TIMEOUT) chk("tmo_rstn", i, rstn_pch, 1'b0);
      if (i == TIMEOUT) chk("tmo_rstn_pre", i, rstn_pch, 1'b1);
    end
    cs_pch = 1'b1;
    release_ch(1, "tmo_rel");

    // Simultaneous requests after reset: BMC first, PCH once BMC is home again.
    rst = 1'b1;
    step();
    rst = 1'b0;
    req_pch = 1'b1;
    acquire(0, "sim_bmc");
    req_bmc = 1'b0;
    for (int i = 0; i <= RST + 1 + 1 + IDLE + RST + GUARD; i++) begin
      step();
      chk("sim_bmc_rstn", i, rstn_bmc, i >= RST);
      chk("sim_bmc_gnt", i, gnt_bmc, 1'b0);
      chk("sim_pch_rstn", i, rstn_pch, !(i >= RST + 2 + IDLE && i < RST + 1 + 29));
      chk("sim_pch_gnt", i, gnt_pch, i >= RST + 1 + 29);
    end
    release_ch(1, "sim_pch_rel");

    // PCH request dropped inside the guard window: no grant, RETURN, then home.
    req_pch = 1'b1;
    step();  // E0
    for (int i = 1; i <= 1 + IDLE + RST + GUARD + RST + 1; i++) begin
      if (i == 1 + IDLE + RST + 2) req_pch = 1'b0;
      step();
      chk("abort_gnt", i, gnt_pch, 1'b0);
      chk("abort_sel", i, sel_pch, i >= 1 + IDLE + RST && i < 1 + IDLE + RST + GUARD);
      chk("abort_rstn", i, rstn_pch, !(i >= 1 + IDLE && i < 1 + IDLE + RST + GUARD + RST));
    end

    // Bypass during ownership: immediate return to host, requests ignored meanwhile.
    acquire(0, "byp_own");
    bypass = 1'b1;
    req_pch = 1'b1;
    step();
    chk_home("byp_bmc", 0, 0);
    for (int i = 1; i <= 40; i++) begin
      step();
      chk_home("byp_hold_bmc", 0, i);
      chk_home("byp_hold_pch", 1, i);
    end
    bypass = 1'b0;
    req_pch = 1'b0;
    acquire(0, "byp_regrant");
    release_ch(0, "byp_rel");

    // Reset in the middle of the reset hold: asynchronous return, then a fresh request.
    req_bmc = 1'b1;
    step();  // E0
    repeat (12) step();
    chk("rsthold_rstn", 12, rstn_bmc, 1'b0);
    rst = 1'b1;
    #1;
    chk_reset_vals("async_rst");
    step();
    rst = 1'b0;
    acquire(0, "post_rst");
    release_ch(0, "post_rst_rel");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
